// File: rtl/ram_weight_copier_if.sv
// Bus between the weight copier and the logic around it: start/busy/done
// handshake plus the source and destination weight-bank connections.
// The copier uses the master modport. The requester/bank side uses slave.
interface ram_weight_copier_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 32,
    parameter int IDX_BITS   = 5
);
    logic                            i_start;
    logic                            o_busy;
    logic                            o_done;
    logic [NUM_WORDS-1:0]            o_src_ram_enable;
    logic [NUM_WORDS*DATA_WIDTH-1:0] i_src_data;
    logic [NUM_WORDS-1:0]            o_dst_ram_enable;
    logic                            o_dst_write_enable;
    logic [DATA_WIDTH-1:0]           o_dst_data;
    logic [IDX_BITS-1:0]             o_word_idx;

    modport master (
        input  i_start, i_src_data,
        output o_busy, o_done, o_src_ram_enable, o_dst_ram_enable,
               o_dst_write_enable, o_dst_data, o_word_idx
    );

    modport slave (
        output i_start, i_src_data,
        input  o_busy, o_done, o_src_ram_enable, o_dst_ram_enable,
               o_dst_write_enable, o_dst_data, o_word_idx
    );
endinterface

// File: rtl/ram_weight_copier.sv
// Sequencer that copies a bank of single-word weight RAMs (policy network)
// into a second bank (target network). Each word takes three cycles:
// a one-hot read, a wait for the 1-cycle RAM latency with capture, and a write.
module ram_weight_copier #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 32,
    parameter int IDX_BITS   = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    ram_weight_copier_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_WORDS - 1);

    state_t                state;
    logic [IDX_BITS-1:0]   index;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  busy_q;
    logic                  done_q;
    logic [NUM_WORDS-1:0]  src_en_q;
    logic [NUM_WORDS-1:0]  dst_en_q;
    logic                  dst_we_q;

    function automatic logic [NUM_WORDS-1:0] one_hot(input logic [IDX_BITS-1:0] idx);
        return NUM_WORDS'(1) << idx;
    endfunction

    // Copy FSM; every output is a register so the enables are glitch-free at the banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            index    <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            src_en_q <= '0;
            dst_en_q <= '0;
            dst_we_q <= 1'b0;
        end else begin
            // NOTE: state and outputs use non-blocking assignments so every
            // branch sees the pre-edge values, like real flops. The defaults
            // below make each enable and strobe a single-cycle pulse.
            done_q   <= 1'b0;
            src_en_q <= '0;
            dst_en_q <= '0;
            dst_we_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        state    <= S_READ;
                        index    <= '0;
                        busy_q   <= 1'b1;
                        src_en_q <= one_hot('0);
                    end
                end
                S_READ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Source o_data is valid this cycle, one cycle after the read enable.
                    data_q   <= bus.i_src_data[index*DATA_WIDTH +: DATA_WIDTH];
                    dst_en_q <= one_hot(index);
                    dst_we_q <= 1'b1;
                    state    <= S_WRITE;
                end
                S_WRITE: begin
                    if (index == LAST_IDX) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        index    <= index + 1'b1;
                        src_en_q <= one_hot(index + 1'b1);
                        state    <= S_READ;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy             = busy_q;
    assign bus.o_done             = done_q;
    assign bus.o_src_ram_enable   = src_en_q;
    assign bus.o_dst_ram_enable   = dst_en_q;
    assign bus.o_dst_write_enable = dst_we_q;
    assign bus.o_dst_data         = data_q;
    assign bus.o_word_idx         = index;
endmodule

// File: tb/tb_ram_weight_copier.sv
// Directed bench for ram_weight_copier: a 4-word instance for timing and
// corner cases, and a 32-word instance for a full-size copy. Behavioural
// RAM banks sit on both sides, and a monitor watches the enable protocol.
module tb_ram_weight_copier;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ram_weight_copier_if #(.DATA_WIDTH(DW), .NUM_WORDS(4),  .IDX_BITS(2)) bus4 ();
    ram_weight_copier_if #(.DATA_WIDTH(DW), .NUM_WORDS(32), .IDX_BITS(5)) bus32 ();

    ram_weight_copier #(.DATA_WIDTH(DW), .NUM_WORDS(4), .IDX_BITS(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.master)
    );
    ram_weight_copier #(.DATA_WIDTH(DW), .NUM_WORDS(32), .IDX_BITS(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(bus32.master)
    );

    // Behavioural banks: a source read registers o_data, and a destination write stores the data.
    logic [DW-1:0] src4_mem [4];
    logic [DW-1:0] src4_q   [4];
    logic [DW-1:0] dst4_mem [4];
    logic [DW-1:0] src32_mem[32];
    logic [DW-1:0] src32_q  [32];
    logic [DW-1:0] dst32_mem[32];

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (bus4.o_src_ram_enable[k]) src4_q[k] <= src4_mem[k];
            if (bus4.o_dst_ram_enable[k] && bus4.o_dst_write_enable) dst4_mem[k] <= bus4.o_dst_data;
        end
        for (int k = 0; k < 32; k++) begin
            if (bus32.o_src_ram_enable[k]) src32_q[k] <= src32_mem[k];
            if (bus32.o_dst_ram_enable[k] && bus32.o_dst_write_enable) dst32_mem[k] <= bus32.o_dst_data;
        end
    end

    always_comb begin
        bus4.i_src_data = '0;
        for (int k = 0; k < 4; k++) bus4.i_src_data[k*DW +: DW] = src4_q[k];
    end

    always_comb begin
        bus32.i_src_data = '0;
        for (int k = 0; k < 32; k++) bus32.i_src_data[k*DW +: DW] = src32_q[k];
    end

    function automatic int enc(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic bad_proto(input logic [31:0] src, input logic [31:0] dst, input logic we);
        return ($countones(src) > 1) || ($countones(dst) > 1) || ((|src) && (|dst)) || (we != (|dst));
    endfunction

    // Write log, done counters and the protocol monitor.
    int wr4_cnt    = 0;
    int wr4_log[64];
    int done4_cnt  = 0;
    int done32_cnt = 0;
    int prot_viol  = 0;

    always_ff @(posedge clk) begin
        if (bus4.o_dst_write_enable) begin
            wr4_log[wr4_cnt[5:0]] <= enc(32'(bus4.o_dst_ram_enable));
            wr4_cnt <= wr4_cnt + 1;
        end
        if (bus4.o_done) done4_cnt <= done4_cnt + 1;
        if (bus32.o_done) done32_cnt <= done32_cnt + 1;
        if (bad_proto(32'(bus4.o_src_ram_enable), 32'(bus4.o_dst_ram_enable), bus4.o_dst_write_enable) ||
            bad_proto(bus32.o_src_ram_enable, bus32.o_dst_ram_enable, bus32.o_dst_write_enable))
            prot_viol <= prot_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge. It returns on the negedge of cycle 1 after the start edge.
    task automatic pulse4();
        bus4.i_start = 1'b1;
        @(negedge clk);
        bus4.i_start = 1'b0;
    endtask

    task automatic wait_done4(input int budget, output int cyc);
        cyc = 0;
        while (!bus4.o_done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("done4 within budget", 32'(cyc < budget), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_wr, base_done, cyc;
        bus4.i_start  = 1'b0;
        bus32.i_start = 1'b0;
        for (int k = 0; k < 32; k++) src32_mem[k] = 32'h9E3779B9 * (k + 1);

        // Reset state
        rst_n = 1'b0;
        tick(2);
        check("rst busy", 32'(bus4.o_busy), 32'd0);
        check("rst done", 32'(bus4.o_done), 32'd0);
        check("rst src_en", 32'(bus4.o_src_ram_enable), 32'd0);
        check("rst dst_en", 32'(bus4.o_dst_ram_enable), 32'd0);
        check("rst we", 32'(bus4.o_dst_write_enable), 32'd0);
        check("rst data", bus4.o_dst_data, 32'd0);
        check("rst idx", 32'(bus4.o_word_idx), 32'd0);
        check("rst32 busy", 32'(bus32.o_busy), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Test 1: basic 4-word copy with cycle-exact timing
        for (int k = 0; k < 4; k++) src4_mem[k] = 32'h11111111 * k;
        base_wr = wr4_cnt; base_done = done4_cnt;
        pulse4();
        for (int c = 1; c <= 13; c++) begin
            check($sformatf("t1 busy c%0d", c), 32'(bus4.o_busy), 32'(c <= 12));
            check($sformatf("t1 done c%0d", c), 32'(bus4.o_done), 32'(c == 13));
            if (c == 1) begin
                check("t1 src_en c1", 32'(bus4.o_src_ram_enable), 32'h1);
                check("t1 idx c1", 32'(bus4.o_word_idx), 32'd0);
            end
            if (c == 2) check("t1 src_en c2", 32'(bus4.o_src_ram_enable), 32'h0);
            if (c == 3) begin
                check("t1 dst_en c3", 32'(bus4.o_dst_ram_enable), 32'h1);
                check("t1 we c3", 32'(bus4.o_dst_write_enable), 32'd1);
                check("t1 data c3", bus4.o_dst_data, 32'h0);
            end
            if (c == 6) begin
                check("t1 dst_en c6", 32'(bus4.o_dst_ram_enable), 32'h2);
                check("t1 data c6", bus4.o_dst_data, 32'h11111111);
            end
            if (c == 12) begin
                check("t1 dst_en c12", 32'(bus4.o_dst_ram_enable), 32'h8);
                check("t1 data c12", bus4.o_dst_data, 32'h33333333);
                check("t1 idx c12", 32'(bus4.o_word_idx), 32'd3);
            end
            if (c < 13) @(negedge clk);
        end
        tick(1);
        check("t1 writes", 32'(wr4_cnt - base_wr), 32'd4);
        check("t1 dones", 32'(done4_cnt - base_done), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t1 order %0d", k), 32'(wr4_log[base_wr + k]), 32'(k));
            check($sformatf("t1 dst %0d", k), dst4_mem[k], 32'h11111111 * k);
        end

        // Test 3: start pulses during a copy are ignored
        for (int k = 0; k < 4; k++) src4_mem[k] = 32'hCAFE0000 + k;
        base_wr = wr4_cnt; base_done = done4_cnt;
        pulse4();
        tick(4); bus4.i_start = 1'b1;
        tick(1); bus4.i_start = 1'b0;
        tick(3); bus4.i_start = 1'b1;
        tick(1); bus4.i_start = 1'b0;
        wait_done4(20, cyc);
        check("t3 done cycle", 32'(cyc), 32'd3);
        tick(10);
        check("t3 busy after", 32'(bus4.o_busy), 32'd0);
        check("t3 writes", 32'(wr4_cnt - base_wr), 32'd4);
        check("t3 dones", 32'(done4_cnt - base_done), 32'd1);
        for (int k = 0; k < 4; k++) check($sformatf("t3 dst %0d", k), dst4_mem[k], 32'hCAFE0000 + k);

        // Test 4: reset during the WRITE of word 2, then a full restart
        for (int k = 0; k < 4; k++) src4_mem[k] = 32'h50000000 + k;
        base_wr = wr4_cnt;
        pulse4();
        tick(8);
        check("t4 dst_en before rst", 32'(bus4.o_dst_ram_enable), 32'h4);
        check("t4 we before rst", 32'(bus4.o_dst_write_enable), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t4 rst busy", 32'(bus4.o_busy), 32'd0);
        check("t4 rst dst_en", 32'(bus4.o_dst_ram_enable), 32'd0);
        check("t4 rst we", 32'(bus4.o_dst_write_enable), 32'd0);
        check("t4 rst src_en", 32'(bus4.o_src_ram_enable), 32'd0);
        check("t4 rst data", bus4.o_dst_data, 32'd0);
        check("t4 rst idx", 32'(bus4.o_word_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        check("t4 idle busy", 32'(bus4.o_busy), 32'd0);
        check("t4 partial writes", 32'(wr4_cnt - base_wr), 32'd2);
        pulse4();
        wait_done4(20, cyc);
        check("t4 done cycle", 32'(cyc), 32'd12);
        tick(1);
        check("t4 writes", 32'(wr4_cnt - base_wr), 32'd6);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t4 order %0d", k), 32'(wr4_log[base_wr + 2 + k]), 32'(k));
            check($sformatf("t4 dst %0d", k), dst4_mem[k], 32'h50000000 + k);
        end

        // Test 5: start held high; a new copy begins on each IDLE cycle
        for (int k = 0; k < 4; k++) src4_mem[k] = 32'hBEEF0000 + k;
        base_wr = wr4_cnt; base_done = done4_cnt;
        bus4.i_start = 1'b1;
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            check($sformatf("t5 done c%0d", c), 32'(bus4.o_done), 32'(c == 13 || c == 27 || c == 41));
            if (c == 14) check("t5 idle busy c14", 32'(bus4.o_busy), 32'd0);
            if (c == 15) check("t5 restart busy c15", 32'(bus4.o_busy), 32'd1);
            if (c == 40) bus4.i_start = 1'b0;
        end
        tick(3);
        check("t5 busy after", 32'(bus4.o_busy), 32'd0);
        check("t5 writes", 32'(wr4_cnt - base_wr), 32'd12);
        check("t5 dones", 32'(done4_cnt - base_done), 32'd3);

        // Test 6: all-ones word 3 only, with no bleed into its neighbours
        src4_mem[0] = '0; src4_mem[1] = '0; src4_mem[2] = '0; src4_mem[3] = 32'hFFFFFFFF;
        pulse4();
        wait_done4(20, cyc);
        tick(3);
        check("t6 dst 0", dst4_mem[0], 32'h0);
        check("t6 dst 1", dst4_mem[1], 32'h0);
        check("t6 dst 2", dst4_mem[2], 32'h0);
        check("t6 dst 3", dst4_mem[3], 32'hFFFFFFFF);
        check("t6 data held", bus4.o_dst_data, 32'hFFFFFFFF);
        check("t6 idx held", 32'(bus4.o_word_idx), 32'd3);

        // Test 2: full 32-word copy on the large instance
        bus32.i_start = 1'b1;
        @(negedge clk);
        bus32.i_start = 1'b0;
        cyc = 0;
        while (!bus32.o_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("t2 done cycle", 32'(cyc), 32'd96);
        tick(2);
        check("t2 dones", 32'(done32_cnt), 32'd1);
        check("t2 busy after", 32'(bus32.o_busy), 32'd0);
        for (int k = 0; k < 32; k++) check($sformatf("t2 dst %0d", k), dst32_mem[k], 32'h9E3779B9 * (k + 1));
        check("protocol violations", 32'(prot_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
